// File: rtl/axi_stream_writer.sv
// axi_stream_writer
// Converts a 32-bit valid/ready stream into AXI4 INCR write bursts.
// A command (start byte address, word count) is split into bursts of at most
// G_MAX_BURST beats; only one burst is ever outstanding (AW -> W -> B).
//
// Ports:
//   s_aclk, s_areset     clock, asynchronous active-high reset
//   cmd_*                command handshake (accepted only while idle)
//   s_t*                 input stream (passed straight through to W)
//   m_axi_aw*/w*/b*      AXI4 write master channels
//   done, error          one-cycle completion pulse, error valid with done
//
// Build option:
//   AXI_STREAM_WRITER_4K_EN  when defined, bursts are also clipped so none
//                            crosses a 4 KB address boundary.
module axi_stream_writer #(
  parameter int          G_ID_WIDTH  = 1,
  parameter int unsigned G_AWID      = 0,
  parameter int          G_MAX_BURST = 16
) (
  input  logic                  s_aclk,
  input  logic                  s_areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [31:0]           cmd_addr,
  input  logic [15:0]           cmd_words,
  input  logic [31:0]           s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [G_ID_WIDTH-1:0] m_axi_awid,
  output logic [31:0]           m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [G_ID_WIDTH-1:0] m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic [8:0]  beats_q, beats_d;   // size of the current burst, 1..256
  logic [8:0]  cnt_q, cnt_d;       // beats still to send in this burst
  logic [7:0]  len_q, len_d;
  logic        sticky_q, sticky_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        awvalid_q, awvalid_d;
  logic        bready_q, bready_d;
  logic        wlast_q, wlast_d;

  logic [31:0] cmd_addr_al;
  logic [31:0] nxt_addr;
  logic        bresp_err;
  logic        unused_ok;

  // Burst length for a burst starting at a with rem words left (rem >= 1).
  function automatic logic [8:0] calc_beats(input logic [31:0] a,
                                            input logic [15:0] rem);
    logic [16:0] b;
    b = {1'b0, rem};
    if (b > 17'(G_MAX_BURST)) b = 17'(G_MAX_BURST);
`ifdef AXI_STREAM_WRITER_4K_EN
    // Words left before the next 4 KB boundary: 1..1024.
    if (b > (17'd1024 - 17'(a[11:2]))) b = 17'd1024 - 17'(a[11:2]);
`else
    if (a[1]) b = b;  // address only matters for the 4 KB clip
`endif
    return b[8:0];
  endfunction

  assign cmd_addr_al = {cmd_addr[31:2], 2'b00};
  assign nxt_addr    = addr_q + {21'd0, beats_q, 2'b00};
  assign bresp_err   = (m_axi_bresp != 2'b00);
  assign unused_ok   = ^{m_axi_bid, cmd_addr[1:0]};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    beats_d  = beats_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    sticky_d = sticky_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        addr_d   = cmd_addr_al;
        rem_d    = cmd_words;
        sticky_d = 1'b0;
        if (cmd_words == 16'd0) begin
          done_d = 1'b1;
        end else begin
          beats_d = calc_beats(cmd_addr_al, cmd_words);
          cnt_d   = beats_d;
          len_d   = 8'(beats_d - 9'd1);
          state_d = S_AW;
        end
      end
      S_AW: if (m_axi_awready) state_d = S_W;
      S_W: if (s_tvalid && m_axi_wready) begin
        cnt_d = cnt_q - 9'd1;
        rem_d = rem_q - 16'd1;
        if (cnt_q == 9'd1) state_d = S_B;
      end
      S_B: if (m_axi_bvalid) begin
        sticky_d = sticky_q | bresp_err;
        if (rem_q != 16'd0) begin
          addr_d  = nxt_addr;
          beats_d = calc_beats(nxt_addr, rem_q);
          cnt_d   = beats_d;
          len_d   = 8'(beats_d - 9'd1);
          state_d = S_AW;
        end else begin
          done_d  = 1'b1;
          err_d   = sticky_q | bresp_err;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    awvalid_d = (state_d == S_AW);
    bready_d  = (state_d == S_B);
    // wlast is registered: look ahead at the count the next cycle will hold.
    wlast_d   = (state_d == S_W) && (cnt_d == 9'd1);
  end

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      beats_q   <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      sticky_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      wlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      beats_q   <= beats_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      sticky_q  <= sticky_d;
      done_q    <= done_d;
      err_q     <= err_d;
      awvalid_q <= awvalid_d;
      bready_q  <= bready_d;
      wlast_q   <= wlast_d;
    end
  end

  // cmd_ready is forced low while reset is held so nothing is accepted then.
  assign cmd_ready     = (state_q == S_IDLE) && !s_areset;
  assign s_tready      = (state_q == S_W) && m_axi_wready;
  assign m_axi_wvalid  = (state_q == S_W) && s_tvalid;
  assign m_axi_wdata   = s_tdata;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wlast   = wlast_q;
  assign m_axi_awid    = G_ID_WIDTH'(G_AWID);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_bready  = bready_q;
  assign done          = done_q;
  assign error         = err_q;

endmodule

// File: tb/tb_axi_stream_writer.sv
// Scoreboard bench for axi_stream_writer: directed commands push expected
// AW/W/done items into queues; a monitor pops and compares on handshakes.
module tb_axi_stream_writer;
  logic        s_aclk = 1'b0;
  logic        s_areset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_words = '0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tready;
  logic [0:0]  awid, bid;
  logic [31:0] awaddr, wdata;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
  logic        done, error;

  axi_stream_writer dut (
    .s_aclk(s_aclk), .s_areset(s_areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_words(cmd_words),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready), .done(done), .error(error)
  );

  always #5 s_aclk = ~s_aclk;
  assign bid = 1'b0;

  typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
  aw_t         exp_aw_q[$];
  logic [32:0] exp_w_q[$];   // {wlast, wdata}
  bit          exp_done_q[$];
  int          lens_q[$];
  logic [31:0] mem [logic [31:0]];

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++; n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic push_burst(input logic [31:0] a, input int len);
    aw_t e;
    e.addr = a; e.len = 8'(len);
    exp_aw_q.push_back(e);
    lens_q.push_back(len);
  endtask

  // ---------------- slave model ----------------
  logic [31:0] waddr;
  bit          pend_b, b_hs, stall;
  int          b_idx, err_burst;

  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0; waddr = 0;
    pend_b = 0; b_idx = 0; err_burst = -1; stall = 0;
    forever begin
      @(negedge s_aclk);
      b_hs = bvalid && bready;
      if (s_areset) pend_b = 0;
      else begin
        if (awvalid && awready) waddr = awaddr;
        if (wvalid && wready) begin
          mem[waddr] = wdata;
          waddr += 32'd4;
          if (wlast) pend_b = 1;
        end
      end
      @(posedge s_aclk); #1;
      awready = 1'($urandom_range(0, 1));
      wready  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (s_areset) bvalid = 0;
      else begin
        if (b_hs) bvalid = 0;
        if (pend_b && !bvalid) begin
          bvalid = 1;
          bresp  = (b_idx == err_burst) ? 2'd2 : 2'd0;
          b_idx++;
          pend_b = 0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  bit          aw_pend, w_open;
  logic [31:0] pend_addr;
  logic [7:0]  pend_len;

  initial begin
    aw_t e;
    logic [32:0] ew;
    aw_pend = 0; w_open = 0;
    forever begin
      @(negedge s_aclk);
      if (s_areset) begin
        aw_pend = 0; w_open = 0;
      end else begin
        if (aw_pend) begin
          chk("aw_hold_valid", awvalid, 1);
          chk("aw_hold_addr", awaddr, pend_addr);
          chk("aw_hold_len", awlen, pend_len);
        end
        aw_pend = awvalid && !awready;
        pend_addr = awaddr; pend_len = awlen;
        if (s_tready) chk("wvalid_mirror", wvalid, s_tvalid);
        if (wvalid) chk("w_after_aw", w_open, 1);
        if (wvalid && wready) begin
          chk("w_expected", exp_w_q.size() > 0, 1);
          if (exp_w_q.size() > 0) begin
            ew = exp_w_q.pop_front();
            chk("wdata", wdata, ew[31:0]);
            chk("wlast", wlast, ew[32]);
          end
          chk("wstrb", wstrb, 4'hF);
          if (wlast) w_open = 0;
        end
        if (awvalid && awready) begin
          chk("aw_expected", exp_aw_q.size() > 0, 1);
          if (exp_aw_q.size() > 0) begin
            e = exp_aw_q.pop_front();
            chk("awaddr", awaddr, e.addr);
            chk("awlen", awlen, e.len);
          end
          chk("aw_consts", {awid, awsize, awburst}, {1'b0, 3'b010, 2'b01});
          w_open = 1;
        end
        if (done) begin
          chk("done_expected", exp_done_q.size() > 0, 1);
          if (exp_done_q.size() > 0) chk("error", error, exp_done_q.pop_front());
        end
      end
    end
  end

  // ---------------- command + stream driver ----------------
  task automatic run_cmd(input logic [31:0] addr, input logic [15:0] words,
                         input logic [31:0] dbase, input bit gaps, input int err_idx,
                         input bit exp_err, input int abort_after);
    int k, cyc, l;
    k = 0;
    while (lens_q.size() > 0) begin
      l = lens_q.pop_front();
      for (int j = 0; j <= l; j++) begin
        exp_w_q.push_back({(j == l), dbase + 32'(k)});
        k++;
      end
    end
    if (abort_after == 0) exp_done_q.push_back(exp_err);
    b_idx = 0; err_burst = err_idx; stall = gaps;
    @(posedge s_aclk); #1;
    cmd_addr = addr; cmd_words = words; cmd_valid = 1;
    cyc = 0;
    forever begin
      @(negedge s_aclk);
      if (cmd_ready) break;
      if (++cyc > 50) begin timeout("cmd_accept"); cmd_valid = 0; return; end
      @(posedge s_aclk); #1;
    end
    @(posedge s_aclk); #1;
    cmd_valid = 0;
    @(negedge s_aclk);
    if (words == 16'd0) begin
      chk("zero_done", done, 1);
      chk("zero_no_aw", awvalid, 0);
      @(posedge s_aclk); #1;
      return;
    end
    chk("aw_latency", awvalid, 1);
    k = 0; cyc = 0;
    @(posedge s_aclk); #1;
    s_tdata = dbase;
    s_tvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
    while (k < int'(words)) begin
      @(negedge s_aclk);
      if (s_tvalid && s_tready) k++;
      if (++cyc > 2000) begin timeout("stream"); break; end
      @(posedge s_aclk); #1;
      if (abort_after > 0 && k == abort_after) break;
      s_tdata  = dbase + 32'(k);
      s_tvalid = (k < int'(words)) && (gaps ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
    s_tvalid = 0;
    if (abort_after > 0) begin
      s_areset = 1; #1;
      chk("rst_valids", {awvalid, wvalid, bready, s_tready, wlast, done, error, cmd_ready}, 8'h00);
      chk("rst_aw", {awaddr, awlen}, 40'h0);
      exp_w_q.delete(); exp_aw_q.delete();
      repeat (2) @(posedge s_aclk);
      #1 s_areset = 0;
      @(negedge s_aclk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_idle_aw", awvalid, 0);
      @(posedge s_aclk); #1;
      return;
    end
    cyc = 0;
    forever begin
      @(negedge s_aclk);
      if (done) break;
      if (++cyc > 500) begin timeout("done"); break; end
    end
    @(posedge s_aclk); #1;
  endtask

  initial begin
    repeat (3) @(posedge s_aclk);
    @(negedge s_aclk);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_outs", {awvalid, wvalid, bready, s_tready, wlast, done, error}, 7'h0);
    chk("reset_aw", {awaddr, awlen}, 40'h0);
    @(posedge s_aclk); #1 s_areset = 0;
    @(negedge s_aclk);
    chk("release_cmd_ready", cmd_ready, 1);

    // single word
    push_burst(32'h0, 0);
    run_cmd(32'h0, 16'd1, 32'hA5A5A5A5, 0, -1, 0, 0);
    chk("mem0", mem[32'h0], 32'hA5A5A5A5);

    // 40 words split 16/16/8
    push_burst(32'h100, 15); push_burst(32'h140, 15); push_burst(32'h180, 7);
    run_cmd(32'h100, 16'd40, 32'h10000000, 0, -1, 0, 0);
    for (int i = 0; i < 40; i++) chk("mem_incr", mem[32'h100 + 32'(4 * i)], 32'h10000000 + 32'(i));

    // 4 KB boundary
`ifdef AXI_STREAM_WRITER_4K_EN
    push_burst(32'hFF8, 1); push_burst(32'h1000, 1);
`else
    push_burst(32'hFF8, 3);
`endif
    run_cmd(32'hFF8, 16'd4, 32'h20000000, 0, -1, 0, 0);

    // low address bits ignored
    push_burst(32'h200, 2);
    run_cmd(32'h203, 16'd3, 32'h30000000, 0, -1, 0, 0);

    // one beat over the max burst
    push_burst(32'h600, 15); push_burst(32'h640, 0);
    run_cmd(32'h600, 16'd17, 32'h40000000, 0, -1, 0, 0);

    // zero words
    run_cmd(32'h700, 16'd0, 32'h0, 0, -1, 0, 0);

    // gaps + error response on second burst
    push_burst(32'h400, 15); push_burst(32'h440, 3);
    run_cmd(32'h400, 16'd20, 32'h50000000, 1, 1, 1, 0);

    // next command clears the sticky error
    push_burst(32'h500, 1);
    run_cmd(32'h500, 16'd2, 32'h58000000, 1, -1, 0, 0);

    // address wrap at 2^32
`ifdef AXI_STREAM_WRITER_4K_EN
    push_burst(32'hFFFFFFF8, 1); push_burst(32'h0, 1);
`else
    push_burst(32'hFFFFFFF8, 3);
`endif
    run_cmd(32'hFFFFFFF8, 16'd4, 32'h60000000, 0, -1, 0, 0);

    // reset in the middle of a 16-beat burst, then a normal command
    push_burst(32'h800, 15);
    run_cmd(32'h800, 16'd16, 32'h70000000, 0, -1, 0, 5);
    push_burst(32'h900, 1);
    run_cmd(32'h900, 16'd2, 32'h80000000, 0, -1, 0, 0);
    chk("mem_after_rst", mem[32'h904], 32'h80000001);

    repeat (5) @(posedge s_aclk);
    chk("aw_q_empty", exp_aw_q.size(), 0);
    chk("w_q_empty", exp_w_q.size(), 0);
    chk("done_q_empty", exp_done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
